// File: rtl/hash_pipe_arbiter.sv
// hash_pipe_arbiter: round-robin front end for one shared, non-stallable hash pipeline.
// A lane tag travels alongside each window. When the pipeline result emerges, the tag
// steers it into that lane's FWFT result FIFO. Per-lane credits cover both in-flight
// tags and buffered results, so a returning result always finds room.
module hash_pipe_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 64,
  parameter int NBITS      = 15,
  parameter int LAT        = 7,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DATA_W-1:0]  req_data,
  output logic                    hash_in_valid,
  output logic [DATA_W-1:0]       hash_in_data,
  input  logic [NBITS-1:0]        hash_out,
  output logic [NREQ-1:0]         res_valid,
  input  logic [NREQ-1:0]         res_ready,
  output logic [NREQ*NBITS-1:0]   res_hash,
  output logic                    idle
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int AW    = $clog2(OBUF_DEPTH);
  localparam int PTR_W = AW + 1;

  logic                 run_q;
  logic [IDX_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     credit   [NREQ];
  logic [NREQ-1:0]      elig;
  logic [NREQ-1:0]      grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [DATA_W-1:0]    data_mux;
  logic [LAT-1:0]       tag_v;
  logic [IDX_W-1:0]     tag_lane [LAT];
  logic [NREQ-1:0]      wr_en;
  logic [NREQ-1:0]      pop;
  logic [PTR_W-1:0]     wr_ptr   [NREQ];
  logic [PTR_W-1:0]     rd_ptr   [NREQ];
  logic [NBITS-1:0]     mem      [NREQ][OBUF_DEPTH];

  // Eligibility: the lane has work and room for its result; nothing issues until
  // the first edge after reset release.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = run_q && req_valid[i] && (credit[i] != '0);
    end
  end

  // Round-robin pick: first eligible lane starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin : arb
    logic [IDX_W-1:0] j;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDX_W'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && elig[j]) begin
        grant[j]  = 1'b1;
        grant_idx = j;
        grant_any = 1'b1;
      end
    end
  end

  // One-hot grant selects the issued window; zero when nothing issues.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) data_mux = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready     = grant;
  assign hash_in_valid = grant_any;
  assign hash_in_data  = data_mux;

  // Run flag and round-robin pointer; the pointer moves just past the granted lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      rr_ptr <= '0;
    end else begin
      run_q <= 1'b1;
      if (grant_any) begin
        rr_ptr <= (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Tag shift register mirrors the pipeline latency; only tags qualify hash_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int s = 0; s < LAT; s++) tag_lane[s] <= '0;
    end else begin
      tag_v[0]    <= grant_any;
      tag_lane[0] <= grant_idx;
      for (int s = 1; s < LAT; s++) begin
        tag_v[s]    <= tag_v[s-1];
        tag_lane[s] <= tag_lane[s-1];
      end
    end
  end

  // Write and pop strobes per lane.
  always_comb begin
    wr_en = '0;
    pop   = '0;
    for (int i = 0; i < NREQ; i++) begin
      wr_en[i] = tag_v[LAT-1] && (tag_lane[LAT-1] == IDX_W'(i));
      pop[i]   = res_valid[i] && res_ready[i];
    end
  end

  // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // Result storage; contents are don't-care until written, the head is masked when empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (wr_en[i]) mem[i][wr_ptr[i][AW-1:0]] <= hash_out;
    end
  end

  // Credits: spent on issue, returned on pop; both in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) credit[i] <= PTR_W'(OBUF_DEPTH);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - 1'b1;
          2'b01:   credit[i] <= credit[i] + 1'b1;
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  // FWFT heads and registered-state idle.
  always_comb begin
    res_valid = '0;
    res_hash  = '0;
    for (int i = 0; i < NREQ; i++) begin
      res_valid[i] = (wr_ptr[i] != rd_ptr[i]);
      if (res_valid[i]) res_hash[i*NBITS +: NBITS] = mem[i][rd_ptr[i][AW-1:0]];
    end
    idle = !(|tag_v) && !(|res_valid);
  end

endmodule

// File: tb/tb_hash_pipe_arbiter.sv
// tb_hash_pipe_arbiter: directed checks of arbitration, latency, credits and reset,
// with a per-lane scoreboard following every accepted window to its result.
module tb_hash_pipe_arbiter;
  localparam int NREQ = 4, DATA_W = 64, NBITS = 15, LAT = 7, OBUF_DEPTH = 4;
  localparam logic [NBITS-1:0] MASK = 15'h5A5A;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid, req_ready, res_valid, res_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   hash_in_valid, idle;
  logic [DATA_W-1:0]      hash_in_data;
  logic [NBITS-1:0]       hash_out;
  logic [NREQ*NBITS-1:0]  res_hash;
  logic [NBITS-1:0]       hpipe [LAT];
  logic [NBITS-1:0]       exp_q [NREQ][$];
  int n_chk = 0, n_err = 0;
  int n2, ni;

  hash_pipe_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .NBITS(NBITS), .LAT(LAT),
                      .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .hash_in_valid(hash_in_valid), .hash_in_data(hash_in_data),
    .hash_out(hash_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_hash(res_hash), .idle(idle));

  always #5 clk = ~clk;

  // Hash pipeline model: fixed latency, free running, never gated.
  always @(posedge clk) begin
    hpipe[0] <= hash_in_data[NBITS-1:0] ^ MASK;
    for (int s = 1; s < LAT; s++) hpipe[s] <= hpipe[s-1];
  end
  assign hash_out = hpipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected result queued at accept, compared at pop.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) exp_q[i].push_back(req_data[i*DATA_W +: NBITS] ^ MASK);
      if (res_valid[i] && res_ready[i]) begin
        chk("sb_has_entry", 64'(exp_q[i].size() != 0), 1);
        if (exp_q[i].size() != 0) chk("sb_hash", res_hash[i*NBITS +: NBITS], exp_q[i].pop_front());
      end
    end
  end

  function automatic int q_total();
    int t = 0;
    for (int i = 0; i < NREQ; i++) t += exp_q[i].size();
    return t;
  endfunction

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!idle && k < 200) begin nxt(); k++; end
    chk(tag, idle, 1);
  endtask

  initial begin
    req_valid = 4'hF; res_ready = '0; rand_data();
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_hin_valid", hash_in_valid, 0);
    chk("rst_hin_data", hash_in_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_hash", res_hash, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk); #1; rst_n = 1'b1; req_valid = '0;
    repeat (3) nxt();

    // 1: single lane-0 window, latency and value
    req_data[63:0] = 64'h0123_4567_89AB_CDEF; req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_hin_valid", hash_in_valid, 1);
    chk("t1_hin_data", hash_in_data, 64'h0123_4567_89AB_CDEF);
    nxt(); req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk); chk("t1_no_early", res_valid[0], 0); nxt();
    end
    res_ready = 4'b0001;
    @(negedge clk);
    chk("t1_res_valid", res_valid[0], 1);
    chk("t1_res_hash", res_hash[NBITS-1:0], 15'h17B5);
    chk("t1_busy", idle, 0);
    nxt(); res_ready = '0;
    @(negedge clk);
    chk("t1_empty", res_valid, 0);
    chk("t1_idle", idle, 1);
    nxt();

    // 2: all lanes, full rate rotation from rr_ptr=1
    res_ready = 4'hF; req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      @(negedge clk); chk("t2_grant", req_ready, 64'(1) << ((1 + k) % NREQ)); nxt();
    end
    req_valid = '0;
    wait_idle("t2_drain");

    // 3: lane 2 stalled on output uses exactly its credits
    res_ready = 4'b1011; req_valid = 4'hF; n2 = 0; ni = 0;
    for (int k = 0; k < 24; k++) begin
      rand_data();
      @(negedge clk); n2 += int'(req_ready[2]); ni += int'(hash_in_valid); nxt();
    end
    chk("t3_l2_grants", n2, 4);
    chk("t3_issue_rate", ni, 24);
    @(negedge clk); chk("t3_l2_blocked", req_ready[2], 0); nxt();
    res_ready = 4'hF;
    @(negedge clk); chk("t3_l2_head", res_valid[2], 1); nxt();
    res_ready = 4'b1011; n2 = 0;
    for (int k = 0; k < 20; k++) begin
      rand_data();
      @(negedge clk); n2 += int'(req_ready[2]); nxt();
    end
    chk("t3_l2_one_more", n2, 1);
    res_ready = 4'hF; req_valid = '0;
    wait_idle("t3_drain");

    // 4: credit=1 with simultaneous pop and issue, then random traffic
    res_ready = '0; req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      @(negedge clk); chk("t4_fill", req_ready, 4'b0010); nxt();
    end
    @(negedge clk); chk("t4_full", req_ready, 0); nxt();
    repeat (LAT + 2) nxt();
    res_ready = 4'b0010;
    @(negedge clk); chk("t4_a_nocredit", req_ready, 0); nxt();
    @(negedge clk); chk("t4_b_credit1", req_ready, 4'b0010); nxt();
    res_ready = '0;
    @(negedge clk); chk("t4_c_credit_kept", req_ready, 4'b0010); nxt();
    @(negedge clk); chk("t4_d_exhausted", req_ready, 0); nxt();
    for (int k = 0; k < 1000; k++) begin
      rand_data();
      req_valid = 4'($urandom_range(0, 15));
      res_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("t4_grant_legal", 64'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
      nxt();
    end
    res_ready = 4'hF; req_valid = '0;
    wait_idle("t4_drain");
    chk("t4_all_returned", q_total(), 0);

    // 5: wrap-around between lanes 3 and 0
    req_valid = 4'b0100;
    @(negedge clk); chk("t5_setup", req_ready, 4'b0100); nxt();
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      @(negedge clk); chk("t5_grant", req_ready, (k % 2 == 0) ? 4'b1000 : 4'b0001); nxt();
    end
    req_valid = '0;
    wait_idle("t5_drain");

    // 6: reset with 3 buffered results and 5 tags in flight
    res_ready = '0; req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      @(negedge clk); chk("t6_fill", req_ready, 4'b0010); nxt();
    end
    req_valid = '0;
    repeat (LAT + 1) nxt();
    @(negedge clk); chk("t6_buffered", res_valid, 4'b0010); nxt();
    req_valid = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      @(negedge clk); chk("t6_grant", req_ready, (k % 2 == 0) ? 4'b0100 : 4'b0001); nxt();
    end
    #1; rst_n = 1'b0; #1;
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_hin_valid", hash_in_valid, 0);
    chk("t6_rst_hin_data", hash_in_data, 0);
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_res_hash", res_hash, 0);
    chk("t6_rst_idle", idle, 1);
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1; req_valid = '0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(negedge clk); chk("t6_no_stale", {idle, res_valid}, 5'b10000); nxt();
    end
    req_valid = 4'b0001;
    for (int k = 0; k < OBUF_DEPTH; k++) begin
      rand_data();
      @(negedge clk); chk("t6_full_credit", req_ready, 4'b0001); nxt();
    end
    @(negedge clk); chk("t6_credit_limit", req_ready, 0); nxt();
    res_ready = 4'hF; req_valid = '0;
    wait_idle("t6_drain");
    chk("t6_all_returned", q_total(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
